// File: rtl/cmp_arbiter.sv
// cmp_arbiter
// Two-port arbiter and sequencer for the shared compare datapath.
// Requester 0 is the branch unit and requester 1 is the multdiv/bounds-check unit.
// A granted request has its operands captured. The operands are then evaluated
// as a - b, and the block returns inequality and signed less-than results.
//
// Ports
//   clock            : rising-edge clock
//   reset            : asynchronous, active-low reset
//   req0, req1       : requests; held with stable operands until the matching ack
//   a0, b0, a1, b1   : two's complement operands of requester 0 / 1
//   ack0, ack1       : one-cycle pulse, operands captured (EVAL cycle)
//   done0, done1     : one-cycle pulse, neq/lt valid for that requester (RESP cycle)
//   neq, lt          : a != b and signed a < b, qualified by done0/done1
//   busy             : high whenever the FSM is not in IDLE
//   grant_id         : current owner of the datapath, meaningful while busy
module cmp_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic             neq,
    output logic             lt,
    output logic             busy,
    output logic             grant_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic             last_q;
    logic             grant_id_q;
    logic             ack0_q;
    logic             ack1_q;
    logic             done0_q;
    logic             done1_q;
    logic             neq_q;
    logic             lt_q;
    logic             busy_q;

    logic             grant_valid_d;
    logic             grant_id_d;
    logic [WIDTH-1:0] sum_d;
    logic             neq_d;
    logic             lt_d;

    // Round-robin pick. On a tie, the requester that did not win last time is granted.
    // A single request is granted outright.
    always_comb begin
        grant_valid_d = req0 | req1;
        grant_id_d    = (req0 & req1) ? ~last_q : req1;
    end

    // Difference of the captured operands. It is consumed in the EVAL cycle,
    // so the results are registered one stage after the operands are captured.
    // Signed less-than comes from the sign bits and the sign of the wrapped
    // difference. When the signs differ, the difference can overflow, so the
    // operand signs alone decide.
    always_comb begin
        sum_d = opa_q + ~opb_q + {{(WIDTH-1){1'b0}}, 1'b1};
        neq_d = |(opa_q ^ opb_q);
        lt_d  = (opa_q[WIDTH-1] & ~opb_q[WIDTH-1])
              | (~opa_q[WIDTH-1] & ~opb_q[WIDTH-1] & sum_d[WIDTH-1])
              | (opa_q[WIDTH-1] & opb_q[WIDTH-1] & sum_d[WIDTH-1]);
    end

    // Sequencer: IDLE -> EVAL -> RESP -> IDLE. Every output is a register.
    // The ack and done pulses are cleared by default and set only in the
    // cycle they belong to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            last_q     <= 1'b1;
            grant_id_q <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            neq_q      <= 1'b0;
            lt_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_valid_d) begin
                        opa_q      <= grant_id_d ? a1 : a0;
                        opb_q      <= grant_id_d ? b1 : b0;
                        grant_id_q <= grant_id_d;
                        last_q     <= grant_id_d;
                        ack0_q     <= ~grant_id_d;
                        ack1_q     <= grant_id_d;
                        busy_q     <= 1'b1;
                        state_q    <= EVAL;
                    end
                end
                EVAL: begin
                    neq_q   <= neq_d;
                    lt_q    <= lt_d;
                    done0_q <= ~grant_id_q;
                    done1_q <= grant_id_q;
                    state_q <= RESP;
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign neq      = neq_q;
    assign lt       = lt_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule
